// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit-side control logic.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ARB,
        LOAD,
        WAIT_LOW,
        WAIT_DONE
    } arb_state_t;

    // Clocks per UART bit; one 10-bit frame is 10*UART_BAUD_DIV cycles.
    localparam int unsigned UART_BAUD_DIV = 5208;
    localparam int unsigned FRAME_CYCLES  = 10 * UART_BAUD_DIV;

endpackage

// File: rtl/uart_tx_arbiter_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         winner,
    output logic                       valid
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared UART transmitter with message locking
// and a sticky watchdog for a transmitter that never finishes a frame.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 60000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   locked,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   timeout_err,
    input  logic                   clr_err
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick_req, pick_oh;
    logic               pick_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [7:0]         win_data;
    logic               last_bit;

    // While locked only the current owner may compete.
    assign pick_req = locked_q ? (req & grant_q) : req;
    assign last_bit = |(req_last & grant_q);

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .valid  (pick_valid)
    );

    always_comb begin
        win_data  = '0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) win_data = req_data[8*i +: 8];
            if (grant_q[i]) grant_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        locked_d  = locked_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        err_d     = clr_err ? 1'b0 : err_q;
        case (state_q)
            ARB: begin
                if (pick_valid) begin
                    grant_d   = pick_oh;
                    tx_data_d = win_data;
                    state_d   = LOAD;
                end else if (!locked_q) begin
                    grant_d = '0;
                end
            end
            LOAD: begin
                cnt_d    = '0;
                ptr_d    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                locked_d = ~last_bit;
                state_d  = WAIT_LOW;
            end
            WAIT_LOW, WAIT_DONE: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                // Watchdog expiry overrides the handshake and wins over clr_err.
                if (cnt_q == CNT_LIMIT) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    grant_d  = '0;
                    state_d  = ARB;
                end else if (state_q == WAIT_LOW && !tx_done) begin
                    state_d = WAIT_DONE;
                end else if (state_q == WAIT_DONE && tx_done) begin
                    state_d = ARB;
                    if (!locked_q) grant_d = '0;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            grant_q   <= '0;
            tx_data_q <= 8'h00;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign ack         = (state_q == LOAD) ? grant_q : '0;
    assign trmt        = (state_q == LOAD);
    assign busy        = (state_q != ARB);
    assign locked      = locked_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: message-level round-robin model,
// requester drivers, a small UART transmitter model and a decoupled monitor.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 300;
    localparam int FRAME   = 20;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 locked;
    logic                 trmt;
    logic [7:0]           tx_data;
    logic                 tx_done = 1'b1;
    logic                 timeout_err;
    logic                 clr_err = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .ack         (ack),
        .grant       (grant),
        .busy        (busy),
        .locked      (locked),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; logic last; int gap; } item_t;
    typedef struct { int idx; logic [7:0] data; logic locked_after; } exp_t;

    item_t plan_q[NUM_REQ][$];
    item_t drv_q[NUM_REQ][$];
    exp_t  sb_q[$];
    item_t cur[NUM_REQ];
    bit    has_item[NUM_REQ];
    int    gap_cnt[NUM_REQ];
    int    wait_cnt[NUM_REQ];

    int m_ptr = 0;
    int m_owner = -1;
    int n_checks = 0;
    int n_pass = 0;
    bit stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: all requesters with bytes left are pending; a lock pins the owner.
    task automatic commit();
        item_t tmp[NUM_REQ][$];
        item_t it;
        int w;
        for (int r = 0; r < NUM_REQ; r++) begin
            tmp[r] = plan_q[r];
            foreach (plan_q[r][j]) drv_q[r].push_back(plan_q[r][j]);
            plan_q[r].delete();
        end
        forever begin
            w = -1;
            if (m_owner >= 0) w = m_owner;
            else for (int k = 0; k < NUM_REQ; k++)
                if (w < 0 && tmp[(m_ptr + k) % NUM_REQ].size() != 0) w = (m_ptr + k) % NUM_REQ;
            if (w < 0 || tmp[w].size() == 0) break;
            it = tmp[w].pop_front();
            sb_q.push_back('{w, it.data, !it.last});
            m_ptr   = (w + 1) % NUM_REQ;
            m_owner = it.last ? -1 : w;
        end
    endtask

    task automatic add(input int r, input logic [7:0] d, input logic last, input int gap);
        plan_q[r].push_back('{d, last, gap});
    endtask

    function automatic bit all_idle();
        bit ok = (req == '0) && (sb_q.size() == 0) && !busy && tx_done;
        for (int r = 0; r < NUM_REQ; r++) ok = ok && !has_item[r] && drv_q[r].size() == 0;
        return ok;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!all_idle() && n < 5000);
        check({name, "_idle"}, 32'(all_idle()), 32'd1);
    endtask

    // Requester drivers: hold req with stable data until ack.
    initial begin
        for (int r = 0; r < NUM_REQ; r++) begin has_item[r] = 0; gap_cnt[r] = 0; wait_cnt[r] = 0; end
        forever begin
            @(negedge clk);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (req[r]) begin
                    if (ack[r]) req[r] = 1'b0;
                    else if (++wait_cnt[r] > 5000) begin
                        check("ack_wait", 32'(r), 32'hFFFF);
                        req[r] = 1'b0;
                    end
                end else begin
                    if (!has_item[r] && drv_q[r].size() != 0) begin
                        cur[r] = drv_q[r].pop_front();
                        has_item[r] = 1;
                        gap_cnt[r] = cur[r].gap;
                    end
                    if (has_item[r]) begin
                        if (gap_cnt[r] == 0) begin
                            req_data[8*r +: 8] = cur[r].data;
                            req_last[r] = cur[r].last;
                            req[r] = 1'b1;
                            has_item[r] = 0;
                            wait_cnt[r] = 0;
                        end else gap_cnt[r]--;
                    end
                end
            end
        end
    end

    // Transmitter model: tx_done drops after trmt, rises FRAME cycles later unless stuck.
    initial begin
        int k;
        forever begin
            @(negedge clk);
            if (trmt && !rst) begin
                tx_done = 1'b0;
                k = 0;
                while (k < FRAME && !rst) begin @(negedge clk); k++; end
                while (stuck && !rst) @(negedge clk);
                tx_done = 1'b1;
            end
        end
    end

    // Monitor: every trmt pops one expected byte.
    initial begin
        bit lock_pend = 0;
        logic exp_lock = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (lock_pend) begin check("locked_after_load", 32'(locked), 32'(exp_lock)); lock_pend = 0; end
            if (trmt) begin
                if (sb_q.size() == 0) check("unexpected_trmt", 32'(ack), 32'h0);
                else begin
                    e = sb_q.pop_front();
                    check("ack", 32'(ack), 32'(1 << e.idx));
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("busy_in_load", 32'(busy), 32'd1);
                    lock_pend = 1;
                    exp_lock = e.locked_after;
                end
            end
        end
    end

    task automatic timeout_run(input string name, input int r, input logic hold_clr);
        int n = 0;
        add(r, 8'(r + 8'h30), 1'b0, 0);
        commit();
        clr_err = hold_clr;
        do begin @(negedge clk); n++; end while (!trmt && n < 200);
        check({name, "_trmt"}, 32'(trmt), 32'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!timeout_err && n < 2 * TIMEOUT);
        check({name, "_latency"}, 32'(n), 32'(TIMEOUT + 1));
        check({name, "_grant"}, 32'(grant), 32'h0);
        check({name, "_locked"}, 32'(locked), 32'h0);
        check({name, "_busy"}, 32'(busy), 32'h0);
        m_owner = -1;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check({name, "_cleared"}, 32'(timeout_err), 32'h0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {trmt, ack, grant, busy, locked, timeout_err, tx_data}, 32'h0);

        add(0, 8'hA5, 1'b1, 0);
        commit();
        wait_idle("single");
        check("single_grant_after", 32'(grant), 32'h0);
        check("single_locked_after", 32'(locked), 32'h0);

        for (int r = 0; r < NUM_REQ; r++) add(r, 8'(8'h10 + r), 1'b1, 0);
        add(0, 8'h20, 1'b1, 0);
        commit();
        wait_idle("round_robin");

        add(0, 8'hC0, 1'b0, 0); add(0, 8'hC1, 1'b0, 0); add(0, 8'hC2, 1'b1, 0);
        add(2, 8'hD2, 1'b1, 0);
        commit();
        wait_idle("lock");

        add(0, 8'hE0, 1'b0, 0); add(0, 8'hE1, 1'b1, 100);
        add(1, 8'hE5, 1'b1, 0);
        commit();
        repeat (60) @(negedge clk);
        check("hold_grant", 32'(grant), 32'h1);
        check("hold_locked", 32'(locked), 32'h1);
        check("hold_busy", 32'(busy), 32'h0);
        wait_idle("lock_hold");

        for (int round = 0; round < 6; round++) begin
            int mask = $urandom_range(1, 15);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (mask[r]) begin
                    int nmsg = $urandom_range(1, 2);
                    for (int m = 0; m < nmsg; m++) begin
                        int len = $urandom_range(1, 3);
                        for (int b = 0; b < len; b++) add(r, 8'($urandom), b == len - 1, 0);
                    end
                end
            end
            commit();
            wait_idle("random");
        end

        stuck = 1'b1;
        timeout_run("timeout", 2, 1'b0);
        timeout_run("timeout_clr_same", 1, 1'b1);
        stuck = 1'b0;
        wait_idle("after_timeout");

        add(1, 8'h77, 1'b1, 0);
        commit();
        n = 0;
        do begin @(negedge clk); n++; end while (!trmt && n < 200);
        repeat (5) @(negedge clk);
        m_ptr = 0;
        m_owner = -1;
        add(0, 8'h90, 1'b1, 0);
        add(3, 8'h93, 1'b1, 0);
        commit();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", {trmt, grant, busy, locked}, 32'h0);
        wait_idle("after_reset");

        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
